// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline control slice:
// opcodes, hazard FSM states and scoreboard entries.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  // x0 never matches: a write to x0 is discarded
  function automatic logic sb_hit(
    input sb_entry_t  e,
    input logic [4:0] a
  );
    return e.valid && (e.rd == a) && (a != 5'd0);
  endfunction

endpackage

// File: rtl/otter_reg_usage.sv
// Decodes which registers an instruction reads/writes.
// Ports: ir in; use_rs1/use_rs2/wr_rd flags (x0 masked) and rs1/rs2/rd out.
module otter_reg_usage (
  input  logic [31:0] ir,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        wr_rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);
  import otter_pkg::*;

  opcode_t opc;
  logic    r1;
  logic    r2;
  logic    wr;
  logic    unused_bits;

  assign opc = opcode_t'(ir[6:0]);
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  assign unused_bits = ^{ir[31:25], ir[14:12]};

  always_comb begin
    r1 = 1'b0;
    r2 = 1'b0;
    wr = 1'b0;
    unique case (opc)
      LUI, AUIPC, JAL: wr = 1'b1;
      JALR: begin
        r1 = 1'b1;
        wr = 1'b1;
      end
      BRANCH, STORE: begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
      LOAD, OP_IMM, SYSTEM: begin
        r1 = 1'b1;
        wr = 1'b1;
      end
      OP: begin
        r1 = 1'b1;
        r2 = 1'b1;
        wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign use_rs1 = r1 && (rs1 != 5'd0);
  assign use_rs2 = r2 && (rs2 != 5'd0);
  assign wr_rd   = wr && (rd != 5'd0);

endmodule

// File: rtl/otter_hazard_ctrl.sv
// RAW-hazard stall and branch/jump flush control beside decode.
// Ports: CLK, RST (sync, active-high), DEC_IR, REDIRECT in;
// PC_WRITE, DEC_EN, DEC_FLUSH, EXE_BUBBLE, STALL out (combinational).
// Option: OTTER_RF_BYPASS_EN drops the wb entry from hazard compares.
module otter_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DEC_IR,
  input  logic        REDIRECT,
  output logic        PC_WRITE,
  output logic        DEC_EN,
  output logic        DEC_FLUSH,
  output logic        EXE_BUBBLE,
  output logic        STALL
);
  import otter_pkg::*;

`ifdef OTTER_RF_BYPASS_EN
  // write-through RF: the wb producer is already visible
  localparam logic WB_CMP = 1'b0;
`else
  localparam logic WB_CMP = 1'b1;
`endif

  localparam logic [1:0] FC_INIT = 2'(FLUSH_CYCLES - 1);

  hz_state_t state;
  logic [1:0] fc;
  sb_entry_t  sb_ex;
  sb_entry_t  sb_mem;
  sb_entry_t  sb_wb;

  logic       use_rs1;
  logic       use_rs2;
  logic       wr_rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  logic in_flush;
  logic hit1;
  logic hit2;
  logic hazard;
  logic advance;

  otter_reg_usage u_usage (
    .ir      (DEC_IR),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .wr_rd   (wr_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd)
  );

  assign in_flush = (state == FLUSH);

  assign hit1 = use_rs1 && (sb_hit(sb_ex, rs1)
             || sb_hit(sb_mem, rs1)
             || (WB_CMP && sb_hit(sb_wb, rs1)));

  assign hit2 = use_rs2 && (sb_hit(sb_ex, rs2)
             || sb_hit(sb_mem, rs2)
             || (WB_CMP && sb_hit(sb_wb, rs2)));

  // decode holds a wrong-path instruction while flushing
  assign hazard  = !in_flush && (hit1 || hit2);
  assign advance = !in_flush && !hazard;

  always_comb begin
    PC_WRITE   = 1'b0;
    DEC_EN     = 1'b0;
    DEC_FLUSH  = 1'b0;
    EXE_BUBBLE = 1'b0;
    STALL      = 1'b0;
    if (RST) begin
      DEC_FLUSH  = 1'b1;
      EXE_BUBBLE = 1'b1;
    end else if (in_flush) begin
      PC_WRITE  = 1'b1;
      DEC_EN    = 1'b1;
      DEC_FLUSH = 1'b1;
    end else if (hazard) begin
      EXE_BUBBLE = 1'b1;
      STALL      = 1'b1;
    end else begin
      PC_WRITE  = 1'b1;
      DEC_EN    = 1'b1;
      DEC_FLUSH = REDIRECT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      fc     <= 2'd0;
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (advance) begin
        sb_ex <= '{valid: wr_rd, rd: rd};
      end else begin
        sb_ex <= '0;
      end
      unique case (state)
        RUN, otter_pkg::STALL: begin
          if (hazard) begin
            state <= otter_pkg::STALL;
          end else if (REDIRECT) begin
            fc    <= FC_INIT;
            state <= (FC_INIT != 2'd0) ? FLUSH : RUN;
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          fc <= fc - 2'd1;
          if (fc <= 2'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          fc    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Self-checking bench for otter_hazard_ctrl.
// Timestamp-based reference model; directed plus random stimulus.
module tb_otter_hazard_ctrl;

  localparam int FC = 2;
`ifdef OTTER_RF_BYPASS_EN
  localparam int WIN = 2;
`else
  localparam int WIN = 3;
`endif

  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_AUI = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JLR = 7'b1100111;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_OP  = 7'b0110011;
  localparam logic [6:0] O_SYS = 7'b1110011;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] dec_ir;
  logic        redirect;
  logic        pc_write;
  logic        dec_en;
  logic        dec_flush;
  logic        exe_bubble;
  logic        stall;

  int checks;
  int errors;
  int cyc;
  int flush_rem;
  int last_issue [32];
  logic [4:0] exp;

  otter_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .CLK        (clk),
    .RST        (rst),
    .DEC_IR     (dec_ir),
    .REDIRECT   (redirect),
    .PC_WRITE   (pc_write),
    .DEC_EN     (dec_en),
    .DEC_FLUSH  (dec_flush),
    .EXE_BUBBLE (exe_bubble),
    .STALL      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(
    input logic [6:0] opc,
    input logic [4:0] rd,
    input logic [4:0] a,
    input logic [4:0] b
  );
    return {7'd0, b, a, 3'd0, rd, opc};
  endfunction

  function automatic logic [4:0] outs();
    return {pc_write, dec_en, dec_flush, exe_bubble, stall};
  endfunction

  // a source is busy if its producer left decode 1..WIN cycles ago
  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && ((cyc - last_issue[r]) <= WIN);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) last_issue[i] = -1000;
    flush_rem = 0;
  endtask

  // drive one cycle and compute the expected outputs
  task automatic apply(
    input logic [31:0] ir,
    input logic        rd_in,
    input logic        r
  );
    logic [6:0] o;
    logic u1, u2, w, haz;
    @(negedge clk);
    cyc++;
    dec_ir   = ir;
    redirect = rd_in;
    rst      = r;
    #1;
    o  = ir[6:0];
    u1 = o inside {O_JLR, O_BR, O_LD, O_ST, O_IMM, O_OP, O_SYS};
    u2 = o inside {O_BR, O_ST, O_OP};
    w  = o inside {O_LUI, O_AUI, O_JAL, O_JLR, O_LD, O_IMM, O_OP, O_SYS};
    haz = (u1 && busy(ir[19:15])) || (u2 && busy(ir[24:20]));
    if (r) begin
      exp = 5'b00110;
      model_clear();
    end else if (flush_rem > 0) begin
      exp = 5'b11100;
      flush_rem--;
    end else if (haz) begin
      exp = 5'b00011;
    end else begin
      exp = {2'b11, rd_in, 2'b00};
      if (rd_in) flush_rem = FC - 1;
      if (w && ir[11:7] != 5'd0) last_issue[ir[11:7]] = cyc;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(NOP, 1'b1, 1'b1);
      checks++;
      if (outs() !== 5'b00110) begin
        errors++;
        $display("FAIL reset got %b want %b", outs(), 5'b00110);
      end
    end
  endtask

  task automatic test_independent();
    for (int i = 1; i <= 4; i++) begin
      apply(mk(O_IMM, 5'(i), 5'd0, 5'd1), 1'b0, 1'b0);
      checks++;
      if (outs() !== exp || outs() !== 5'b11000) begin
        errors++;
        $display("FAIL indep i=%0d got %b want %b", i, outs(), exp);
      end
    end
  endtask

  task automatic test_raw();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) apply(NOP, 1'b0, 1'b0);
    apply(mk(O_IMM, 5'd5, 5'd0, 5'd1), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(mk(O_OP, 5'd6, 5'd5, 5'd5), 1'b0, 1'b0);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL raw cyc=%0d got %b want %b", i, outs(), exp);
      end
      if (!stall) break;
      n++;
    end
    checks++;
    if (n != WIN) begin
      errors++;
      $display("FAIL raw_len got %0d want %0d", n, WIN);
    end
  endtask

  task automatic test_x0();
    for (int i = 0; i < 4; i++) apply(NOP, 1'b0, 1'b0);
    apply(mk(O_IMM, 5'd0, 5'd0, 5'd1), 1'b0, 1'b0);
    apply(mk(O_OP, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0);
    checks++;
    if (outs() !== exp || stall !== 1'b0) begin
      errors++;
      $display("FAIL x0 got %b want %b", outs(), exp);
    end
  endtask

  task automatic test_redirect();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) apply(NOP, 1'b0, 1'b0);
    apply(mk(O_BR, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0);
    for (int i = 0; i < FC + 1; i++) begin
      if (i > 0) apply(NOP, 1'b0, 1'b0);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL redir i=%0d got %b want %b", i, outs(), exp);
      end
      if (dec_flush && pc_write) n++;
    end
    checks++;
    if (n != FC) begin
      errors++;
      $display("FAIL redir_len got %0d want %0d", n, FC);
    end
  endtask

  task automatic test_load_jalr();
    int n;
    logic fired;
    n = 0;
    fired = 1'b0;
    for (int i = 0; i < 4; i++) apply(NOP, 1'b0, 1'b0);
    apply(mk(O_LD, 5'd7, 5'd1, 5'd0), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(mk(O_JLR, 5'd0, 5'd7, 5'd0), 1'b1, 1'b0);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL jalr i=%0d got %b want %b", i, outs(), exp);
      end
      if (!stall) begin
        fired = dec_flush;
        break;
      end
      n++;
    end
    checks++;
    if (n != WIN || fired !== 1'b1) begin
      errors++;
      $display("FAIL jalr_seq got %0d/%b want %0d/1", n, fired, WIN);
    end
    for (int i = 0; i < FC; i++) apply(NOP, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 4; i++) apply(NOP, 1'b0, 1'b0);
    apply(mk(O_IMM, 5'd5, 5'd0, 5'd1), 1'b0, 1'b0);
    apply(mk(O_OP, 5'd6, 5'd5, 5'd5), 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall1 got %b want 1", stall);
    end
    apply(mk(O_OP, 5'd6, 5'd5, 5'd5), 1'b0, 1'b1);
    checks++;
    if (outs() !== 5'b00110) begin
      errors++;
      $display("FAIL rst_mid got %b want %b", outs(), 5'b00110);
    end
    apply(mk(O_OP, 5'd6, 5'd5, 5'd5), 1'b0, 1'b0);
    checks++;
    if (outs() !== exp || outs() !== 5'b11000) begin
      errors++;
      $display("FAIL rst_resume got %b want %b", outs(), exp);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    logic [6:0] o;
    ops = '{O_LUI, O_AUI, O_JAL, O_JLR, O_BR, O_LD,
            O_ST, O_IMM, O_OP, O_SYS, 7'b0001111};
    for (int i = 0; i < 600; i++) begin
      o = ops[$urandom_range(0, 10)];
      apply(mk(o, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7))),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 63) == 0));
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL rand i=%0d got %b want %b", i, outs(), exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b1;
    redirect = 1'b0;
    dec_ir   = NOP;
    exp      = '0;
    model_clear();
    test_reset();
    test_independent();
    test_raw();
    test_x0();
    test_redirect();
    test_load_jalr();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
